knn_blk_sched: RTL and testbench
================================

// Module: knn_blk_sched
// PURPOSE
//  Block scheduler in front of the KNN engine. Splits a point cloud of NumBlk equal blocks into per-block KNN runs.
//  Per block: resets and configures KNN, rebases its local coord-fetch addresses to global GLB addresses,
//  and generates sequential GLB write addresses for the map words. Sits between CCU, KNN and GLB.
// PARAMETERS
//  IDX_WIDTH   10  local point index width; KNN block holds <= 2**IDX_WIDTH points
//  MAP_WIDTH   5   width of K config field
//  BLK_WIDTH   8   block count field width
//  ADDR_WIDTH  16  GLB global address width (coord and map address spaces)
// PORTS
//  clk                 in   1          clock
//  rst_n               in   1          async reset, active low
//  CCUSCH_CfgVld       in   1          job config valid
//  SCHCCU_CfgRdy       out  1          scheduler idle, accepts job
//  CCUSCH_CfgNumBlk    in   BLK_WIDTH  number of blocks minus 1
//  CCUSCH_CfgNip       in   IDX_WIDTH  points per block minus 1
//  CCUSCH_CfgK         in   MAP_WIDTH  K passed to KNN
//  CCUSCH_CfgCrdBase   in   ADDR_WIDTH global coord base address
//  CCUSCH_CfgMapBase   in   ADDR_WIDTH global map base address
//  CCUSCH_Abort        in   1          abort current job
//  SCHCCU_Done         out  1          one-cycle pulse: job finished
//  SCHCCU_StallCnt     out  32         coord-fetch stall cycles (see CONFIGURATION)
//  SCHKNN_Rst          out  1          KNN counter clear pulse
//  SCHKNN_CfgVld       out  1          KNN config valid
//  KNNSCH_CfgRdy       in   1          KNN idle / config ready
//  SCHKNN_CfgNip       out  IDX_WIDTH  registered Nip to KNN
//  SCHKNN_CfgK         out  MAP_WIDTH  registered K to KNN
//  KNNSCH_CrdAddr      in   IDX_WIDTH  KNN local coord address
//  KNNSCH_CrdAddrVld   in   1          KNN address valid
//  SCHKNN_CrdAddrRdy   out  1          = GLBSCH_CrdAddrRdy (combinational)
//  SCHGLB_CrdAddr      out  ADDR_WIDTH CrdBase + BlkOff + KNNSCH_CrdAddr, mod 2**ADDR_WIDTH
//  SCHGLB_CrdAddrVld   out  1          = KNNSCH_CrdAddrVld & state==RUN
//  GLBSCH_CrdAddrRdy   in   1          GLB accepts address
//  KNNSCH_MapHs        in   1          KNN map-word handshake (MapVld & MapRdy)
//  SCHGLB_MapAddr      out  ADDR_WIDTH write address of current map word
// BEHAVIOUR
//  Reset: state IDLE; all outputs 0 except SCHCCU_CfgRdy=1; BlkIdx, BlkOff, MapCnt, regs = 0.
//  FSM (SCHCCU_CfgRdy = state==IDLE):
//   IDLE : CfgVld&CfgRdy -> latch all Cfg*, BlkIdx=0, BlkOff=0, MapCnt=0; -> RST
//   RST  : SCHKNN_Rst=1 exactly one cycle -> CFG
//   CFG  : SCHKNN_CfgVld=1 until KNNSCH_CfgRdy; on handshake -> RUN
//   RUN  : wait KNNSCH_CfgRdy==1 (KNN back in IDLE; it is 0 in first RUN cycle) ->
//          BlkIdx==NumBlk ? DONE : (BlkIdx+=1, BlkOff+=Nip+1, -> RST)
//   DONE : SCHCCU_Done=1 one cycle -> IDLE
//  BlkOff updated by accumulation only (no multiplier); wraps mod 2**ADDR_WIDTH, no error.
//  Addr path combinational, zero latency; SCHGLB_CrdAddrVld and SCHKNN_CrdAddrRdy forced 0 outside RUN.
//  SCHGLB_MapAddr = MapBase + MapCnt; MapCnt+=1 per KNNSCH_MapHs in RUN; not cleared between blocks,
//   so maps of consecutive blocks are packed contiguously; wraps mod 2**ADDR_WIDTH.
//  KNNSCH_MapHs outside RUN ignored.
//  Abort (any non-IDLE state): next cycle state=RST-abort: one SCHKNN_Rst pulse, then IDLE; no Done pulse.
//   Abort and RUN completion same cycle: abort wins. Abort in IDLE ignored.
//  CfgVld while busy ignored (CfgRdy=0). Async reset mid-job: immediate return to reset values.
//  NumBlk=0 -> single block run.
// CONFIGURATION
//  KNN_SCHED_PERF_EN defined: SCHCCU_StallCnt counts cycles with SCHGLB_CrdAddrVld & ~GLBSCH_CrdAddrRdy;
//   cleared on job accept, saturates at 2**32-1, held after Done.
//  Not defined: SCHCCU_StallCnt tied to 0, no counter logic.
// TESTING
//  NumBlk=0,Nip=15,K=4,CrdBase=0x100: one RST pulse, one KNN cfg, addresses 0x100..0x10F, one Done.
//  NumBlk=2,Nip=7,CrdBase=0: 3 RST pulses; block 2 local addr 3 -> SCHGLB_CrdAddr=0x13; Done after 3rd CfgRdy.
//  MapBase=0x200, 5 map handshakes blk0 + 5 blk1 -> MapAddr runs 0x200..0x209 without gap.
//  Abort in RUN of blk1 -> one SCHKNN_Rst, IDLE next, SCHCCU_Done never asserted, CfgRdy=1.
//  CrdBase=0xFFF8,Nip=15,local 10 -> SCHGLB_CrdAddr=0x0002 (wrap).
//  PERF_EN: GLB rdy low 7 cycles while addr valid -> StallCnt=7 at Done; without macro StallCnt=0.

Source files
------------

// File: rtl/knn_blk_sched.sv
// Block scheduler: runs KNN once per equal-size block, rebasing coord reads and packing map writes in GLB.
// Optional coord-fetch stall counter is built only when KNN_SCHED_PERF_EN is defined.
module knn_blk_sched #(
    parameter int IDX_WIDTH  = 10,
    parameter int MAP_WIDTH  = 5,
    parameter int BLK_WIDTH  = 8,
    parameter int ADDR_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  CCUSCH_CfgVld,
    output logic                  SCHCCU_CfgRdy,
    input  logic [BLK_WIDTH-1:0]  CCUSCH_CfgNumBlk,
    input  logic [IDX_WIDTH-1:0]  CCUSCH_CfgNip,
    input  logic [MAP_WIDTH-1:0]  CCUSCH_CfgK,
    input  logic [ADDR_WIDTH-1:0] CCUSCH_CfgCrdBase,
    input  logic [ADDR_WIDTH-1:0] CCUSCH_CfgMapBase,
    input  logic                  CCUSCH_Abort,
    output logic                  SCHCCU_Done,
    output logic [31:0]           SCHCCU_StallCnt,
    output logic                  SCHKNN_Rst,
    output logic                  SCHKNN_CfgVld,
    input  logic                  KNNSCH_CfgRdy,
    output logic [IDX_WIDTH-1:0]  SCHKNN_CfgNip,
    output logic [MAP_WIDTH-1:0]  SCHKNN_CfgK,
    input  logic [IDX_WIDTH-1:0]  KNNSCH_CrdAddr,
    input  logic                  KNNSCH_CrdAddrVld,
    output logic                  SCHKNN_CrdAddrRdy,
    output logic [ADDR_WIDTH-1:0] SCHGLB_CrdAddr,
    output logic                  SCHGLB_CrdAddrVld,
    input  logic                  GLBSCH_CrdAddrRdy,
    input  logic                  KNNSCH_MapHs,
    output logic [ADDR_WIDTH-1:0] SCHGLB_MapAddr
);

    typedef enum logic [2:0] {
        S_IDLE, S_RST, S_CFG, S_RUN, S_DONE, S_ABRT
    } state_t;

    localparam logic [ADDR_WIDTH-1:0] A_ONE = ADDR_WIDTH'(1);
    localparam logic [BLK_WIDTH-1:0]  B_ONE = BLK_WIDTH'(1);

    state_t                r_state;
    logic                  r_cfg_rdy;
    logic                  r_knn_rst;
    logic                  r_knn_cfg_vld;
    logic                  r_done;
    logic                  r_run;
    logic [BLK_WIDTH-1:0]  r_num_blk;
    logic [BLK_WIDTH-1:0]  r_blk_idx;
    logic [IDX_WIDTH-1:0]  r_nip;
    logic [MAP_WIDTH-1:0]  r_k;
    logic [ADDR_WIDTH-1:0] r_crd_base;
    logic [ADDR_WIDTH-1:0] r_map_base;
    logic [ADDR_WIDTH-1:0] r_blk_off;
    logic [ADDR_WIDTH-1:0] r_map_cnt;

    logic                  w_accept;
    logic                  w_abort;
    logic                  w_crd_vld;
    logic [ADDR_WIDTH-1:0] w_blk_size;

    assign w_accept   = (r_state == S_IDLE) && CCUSCH_CfgVld;
    // An abort already in flight is not restarted, so one abort gives exactly one KNN reset.
    assign w_abort    = CCUSCH_Abort && (r_state != S_IDLE) && (r_state != S_ABRT);
    assign w_blk_size = ADDR_WIDTH'(r_nip) + A_ONE;
    assign w_crd_vld  = KNNSCH_CrdAddrVld && r_run;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= S_IDLE;
            r_cfg_rdy     <= 1'b1;
            r_knn_rst     <= 1'b0;
            r_knn_cfg_vld <= 1'b0;
            r_done        <= 1'b0;
            r_run         <= 1'b0;
            r_num_blk     <= '0;
            r_blk_idx     <= '0;
            r_nip         <= '0;
            r_k           <= '0;
            r_crd_base    <= '0;
            r_map_base    <= '0;
            r_blk_off     <= '0;
            r_map_cnt     <= '0;
        end else begin
            r_knn_rst <= 1'b0;
            r_done    <= 1'b0;
            if (r_run && KNNSCH_MapHs) begin
                r_map_cnt <= r_map_cnt + A_ONE;
            end
            if (w_abort) begin
                r_state       <= S_ABRT;
                r_knn_rst     <= 1'b1;
                r_knn_cfg_vld <= 1'b0;
                r_run         <= 1'b0;
                r_cfg_rdy     <= 1'b0;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        if (CCUSCH_CfgVld) begin
                            r_num_blk  <= CCUSCH_CfgNumBlk;
                            r_nip      <= CCUSCH_CfgNip;
                            r_k        <= CCUSCH_CfgK;
                            r_crd_base <= CCUSCH_CfgCrdBase;
                            r_map_base <= CCUSCH_CfgMapBase;
                            r_blk_idx  <= '0;
                            r_blk_off  <= '0;
                            r_map_cnt  <= '0;
                            r_state    <= S_RST;
                            r_knn_rst  <= 1'b1;
                            r_cfg_rdy  <= 1'b0;
                        end
                    end
                    S_RST: begin
                        r_state       <= S_CFG;
                        r_knn_cfg_vld <= 1'b1;
                    end
                    S_CFG: begin
                        if (KNNSCH_CfgRdy) begin
                            r_state       <= S_RUN;
                            r_knn_cfg_vld <= 1'b0;
                            r_run         <= 1'b1;
                        end
                    end
                    S_RUN: begin
                        // KNN raising CfgRdy again means it has returned to idle after this block.
                        if (KNNSCH_CfgRdy) begin
                            r_run <= 1'b0;
                            if (r_blk_idx == r_num_blk) begin
                                r_state <= S_DONE;
                                r_done  <= 1'b1;
                            end else begin
                                r_blk_idx <= r_blk_idx + B_ONE;
                                r_blk_off <= r_blk_off + w_blk_size;
                                r_state   <= S_RST;
                                r_knn_rst <= 1'b1;
                            end
                        end
                    end
                    S_DONE: begin
                        r_state   <= S_IDLE;
                        r_cfg_rdy <= 1'b1;
                    end
                    S_ABRT: begin
                        r_state   <= S_IDLE;
                        r_cfg_rdy <= 1'b1;
                    end
                    default: begin
                        r_state   <= S_IDLE;
                        r_cfg_rdy <= 1'b1;
                    end
                endcase
            end
        end
    end

`ifdef KNN_SCHED_PERF_EN
    logic [31:0] r_stall_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stall_cnt <= '0;
        end else if (w_accept) begin
            r_stall_cnt <= '0;
        end else if (w_crd_vld && !GLBSCH_CrdAddrRdy && (r_stall_cnt != 32'hFFFF_FFFF)) begin
            r_stall_cnt <= r_stall_cnt + 32'd1;
        end
    end

    assign SCHCCU_StallCnt = r_stall_cnt;
`else
    assign SCHCCU_StallCnt = 32'd0;
`endif

    assign SCHCCU_CfgRdy     = r_cfg_rdy;
    assign SCHCCU_Done       = r_done;
    assign SCHKNN_Rst        = r_knn_rst;
    assign SCHKNN_CfgVld     = r_knn_cfg_vld;
    assign SCHKNN_CfgNip     = r_nip;
    assign SCHKNN_CfgK       = r_k;
    // Address path is pure combinational passthrough with rebasing; wraps silently.
    assign SCHGLB_CrdAddr    = r_crd_base + r_blk_off + ADDR_WIDTH'(KNNSCH_CrdAddr);
    assign SCHGLB_CrdAddrVld = w_crd_vld;
    assign SCHKNN_CrdAddrRdy = GLBSCH_CrdAddrRdy && r_run;
    assign SCHGLB_MapAddr    = r_map_base + r_map_cnt;

endmodule

// File: tb/tb_knn_blk_sched.sv
// Directed bench for knn_blk_sched: table of whole jobs plus abort/reset corner sequences.
module tb_knn_blk_sched;

    logic        clk;
    logic        rst_n;
    logic        cfg_vld;
    logic        cfg_rdy_o;
    logic [7:0]  cfg_numblk;
    logic [9:0]  cfg_nip;
    logic [4:0]  cfg_k;
    logic [15:0] cfg_crdbase;
    logic [15:0] cfg_mapbase;
    logic        abort;
    logic        done_o;
    logic [31:0] stall_o;
    logic        knn_rst_o;
    logic        knn_cfgvld_o;
    logic        knn_cfg_rdy;
    logic [9:0]  knn_nip_o;
    logic [4:0]  knn_k_o;
    logic [9:0]  crd_addr;
    logic        crd_vld;
    logic        crd_rdy_o;
    logic [15:0] glb_crd_o;
    logic        glb_vld_o;
    logic        glb_rdy;
    logic        map_hs;
    logic [15:0] map_addr_o;

`ifdef KNN_SCHED_PERF_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    knn_blk_sched dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .CCUSCH_CfgVld     (cfg_vld),
        .SCHCCU_CfgRdy     (cfg_rdy_o),
        .CCUSCH_CfgNumBlk  (cfg_numblk),
        .CCUSCH_CfgNip     (cfg_nip),
        .CCUSCH_CfgK       (cfg_k),
        .CCUSCH_CfgCrdBase (cfg_crdbase),
        .CCUSCH_CfgMapBase (cfg_mapbase),
        .CCUSCH_Abort      (abort),
        .SCHCCU_Done       (done_o),
        .SCHCCU_StallCnt   (stall_o),
        .SCHKNN_Rst        (knn_rst_o),
        .SCHKNN_CfgVld     (knn_cfgvld_o),
        .KNNSCH_CfgRdy     (knn_cfg_rdy),
        .SCHKNN_CfgNip     (knn_nip_o),
        .SCHKNN_CfgK       (knn_k_o),
        .KNNSCH_CrdAddr    (crd_addr),
        .KNNSCH_CrdAddrVld (crd_vld),
        .SCHKNN_CrdAddrRdy (crd_rdy_o),
        .SCHGLB_CrdAddr    (glb_crd_o),
        .SCHGLB_CrdAddrVld (glb_vld_o),
        .GLBSCH_CrdAddrRdy (glb_rdy),
        .KNNSCH_MapHs      (map_hs),
        .SCHGLB_MapAddr    (map_addr_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;
    int mon_rst  = 0;
    int mon_done = 0;

    always @(negedge clk) begin
        if (knn_rst_o === 1'b1) mon_rst <= mon_rst + 1;
        if (done_o === 1'b1)    mon_done <= mon_done + 1;
    end

    typedef struct {
        logic [7:0]  numblk;
        logic [9:0]  nip;
        logic [4:0]  k;
        logic [15:0] crdbase;
        logic [15:0] mapbase;
        int          probe_blk;
        logic [9:0]  probe_loc;
        logic [15:0] exp_addr;
        int          exp_rst;
        int          n_map;
        int          n_stall;
        logic [15:0] exp_map_end;
    } vec_t;

    vec_t vecs[7];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic idle_inputs();
        cfg_vld     = 1'b0;
        abort       = 1'b0;
        knn_cfg_rdy = 1'b1;
        crd_addr    = '0;
        crd_vld     = 1'b0;
        glb_rdy     = 1'b1;
        map_hs      = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        idle_inputs();
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic start_job(input logic [7:0] nb, input logic [9:0] nip, input logic [4:0] k,
                             input logic [15:0] cb, input logic [15:0] mb);
        cfg_numblk  = nb;
        cfg_nip     = nip;
        cfg_k       = k;
        cfg_crdbase = cb;
        cfg_mapbase = mb;
        cfg_vld     = 1'b1;
        @(posedge clk); #1;
        cfg_vld     = 1'b0;
    endtask

    // Waits for the KNN config request, accepts it, then spends one busy cycle in RUN.
    task automatic knn_cfg_hs(input logic [9:0] e_nip, input logic [4:0] e_k, output bit ok);
        int n;
        n = 0;
        while (knn_cfgvld_o !== 1'b1 && n < 8) begin
            @(posedge clk); #1;
            n++;
        end
        ok = (n < 8);
        chk("cfg_vld_wait", 32'(ok), 32'd1);
        if (!ok) return;
        chk("cfg_nip", 32'(knn_nip_o), 32'(e_nip));
        chk("cfg_k", 32'(knn_k_o), 32'(e_k));
        @(posedge clk); #1;
        knn_cfg_rdy = 1'b0;
        chk("cfgvld_after_hs", 32'(knn_cfgvld_o), 32'd0);
        @(posedge clk); #1;
    endtask

    task automatic run_vec(input int i);
        vec_t        v;
        logic [15:0] exp_map;
        int          r0;
        int          d0;
        bit          ok;
        v       = vecs[i];
        exp_map = v.mapbase;
        r0      = mon_rst;
        d0      = mon_done;
        start_job(v.numblk, v.nip, v.k, v.crdbase, v.mapbase);
        chk("accept_cfgrdy", 32'(cfg_rdy_o), 32'd0);
        chk("accept_rst", 32'(knn_rst_o), 32'd1);
        for (int b = 0; b <= int'(v.numblk); b++) begin
            knn_cfg_hs(v.nip, v.k, ok);
            if (!ok) begin
                do_reset();
                return;
            end
            for (int m = 0; m < v.n_map; m++) begin
                chk("map_addr", 32'(map_addr_o), 32'(exp_map));
                map_hs = 1'b1;
                @(posedge clk); #1;
                map_hs = 1'b0;
                exp_map = exp_map + 16'd1;
            end
            if (b == v.probe_blk) begin
                crd_addr = v.probe_loc;
                crd_vld  = 1'b1;
                glb_rdy  = 1'b0;
                for (int s = 0; s < v.n_stall; s++) begin
                    @(posedge clk); #1;
                end
                glb_rdy = 1'b1;
                #1;
                chk("crd_addr", 32'(glb_crd_o), 32'(v.exp_addr));
                chk("crd_vld", 32'(glb_vld_o), 32'd1);
                chk("crd_rdy", 32'(crd_rdy_o), 32'd1);
                @(posedge clk); #1;
                crd_vld = 1'b0;
            end
            knn_cfg_rdy = 1'b1;
            @(posedge clk); #1;
        end
        chk("done_pulse", 32'(done_o), 32'd1);
        chk("map_end", 32'(map_addr_o), 32'(v.exp_map_end));
        chk("stall_at_done", stall_o, PERF ? 32'(v.n_stall) : 32'd0);
        @(posedge clk); #1;
        chk("idle_cfgrdy", 32'(cfg_rdy_o), 32'd1);
        chk("done_cleared", 32'(done_o), 32'd0);
        chk("stall_held", stall_o, PERF ? 32'(v.n_stall) : 32'd0);
        chk("rst_pulses", 32'(mon_rst - r0), 32'(v.exp_rst));
        chk("done_pulses", 32'(mon_done - d0), 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit ok;
        int r0;
        int d0;

        //          nb  nip   k  crdbase   mapbase   pb loc  exp_addr  rst map stall mapend
        vecs[0] = '{8'd0, 10'd15,   5'd4, 16'h0100, 16'h0000, 0, 10'd0,  16'h0100, 1, 0, 0, 16'h0000};
        vecs[1] = '{8'd0, 10'd15,   5'd4, 16'h0100, 16'h0000, 0, 10'd15, 16'h010F, 1, 2, 0, 16'h0002};
        vecs[2] = '{8'd2, 10'd7,    5'd3, 16'h0000, 16'h0040, 2, 10'd3,  16'h0013, 3, 1, 2, 16'h0043};
        vecs[3] = '{8'd1, 10'd7,    5'd2, 16'h0800, 16'h0200, 1, 10'd0,  16'h0808, 2, 5, 7, 16'h020A};
        vecs[4] = '{8'd0, 10'd15,   5'd1, 16'hFFF8, 16'hFFFE, 0, 10'd10, 16'h0002, 1, 3, 0, 16'h0001};
        vecs[5] = '{8'd3, 10'd99,   5'd5, 16'h1000, 16'h0000, 3, 10'd0,  16'h112C, 4, 0, 1, 16'h0000};
        vecs[6] = '{8'd1, 10'd1023, 5'd0, 16'h0010, 16'h0000, 1, 10'd5,  16'h0415, 2, 1, 0, 16'h0002};

        rst_n = 1'b0;
        cfg_numblk = '0; cfg_nip = '0; cfg_k = '0; cfg_crdbase = '0; cfg_mapbase = '0;
        idle_inputs();
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;

        chk("rst_cfgrdy", 32'(cfg_rdy_o), 32'd1);
        chk("rst_done", 32'(done_o), 32'd0);
        chk("rst_knnrst", 32'(knn_rst_o), 32'd0);
        chk("rst_cfgvld", 32'(knn_cfgvld_o), 32'd0);
        chk("rst_nip", 32'(knn_nip_o), 32'd0);
        chk("rst_mapaddr", 32'(map_addr_o), 32'd0);
        chk("rst_stall", stall_o, 32'd0);

        for (int i = 0; i < 7; i++) run_vec(i);

        // Abort and map handshakes while idle are both ignored.
        abort  = 1'b1;
        map_hs = 1'b1;
        @(posedge clk); #1;
        abort  = 1'b0;
        map_hs = 1'b0;
        chk("idle_abort_rst", 32'(knn_rst_o), 32'd0);
        chk("idle_abort_rdy", 32'(cfg_rdy_o), 32'd1);
        chk("idle_map_hold", 32'(map_addr_o), 32'h0002);

        // Abort during RUN of block 1; a config request while busy is ignored.
        r0 = mon_rst;
        d0 = mon_done;
        start_job(8'd2, 10'd7, 5'd3, 16'h0000, 16'h0000);
        knn_cfg_hs(10'd7, 5'd3, ok);
        knn_cfg_rdy = 1'b1;
        @(posedge clk); #1;
        knn_cfg_hs(10'd7, 5'd3, ok);
        cfg_vld = 1'b1;
        #1;
        chk("busy_cfgrdy", 32'(cfg_rdy_o), 32'd0);
        abort = 1'b1;
        @(posedge clk); #1;
        abort   = 1'b0;
        cfg_vld = 1'b0;
        chk("abort_rst", 32'(knn_rst_o), 32'd1);
        chk("abort_cfgrdy0", 32'(cfg_rdy_o), 32'd0);
        @(posedge clk); #1;
        chk("abort_rst_end", 32'(knn_rst_o), 32'd0);
        chk("abort_idle", 32'(cfg_rdy_o), 32'd1);
        knn_cfg_rdy = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("abort_rst_cnt", 32'(mon_rst - r0), 32'd3);
        chk("abort_no_done", 32'(mon_done - d0), 32'd0);

        // Address valid/ready gated outside RUN, then abort coinciding with block completion.
        r0 = mon_rst;
        d0 = mon_done;
        start_job(8'd0, 10'd3, 5'd1, 16'h0000, 16'h0000);
        crd_vld = 1'b1;
        glb_rdy = 1'b1;
        #1;
        chk("gate_vld_rst", 32'(glb_vld_o), 32'd0);
        chk("gate_rdy_rst", 32'(crd_rdy_o), 32'd0);
        crd_vld = 1'b0;
        knn_cfg_hs(10'd3, 5'd1, ok);
        knn_cfg_rdy = 1'b1;
        abort       = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        chk("abort_win_rst", 32'(knn_rst_o), 32'd1);
        chk("abort_win_done", 32'(done_o), 32'd0);
        @(posedge clk); #1;
        chk("abort_win_idle", 32'(cfg_rdy_o), 32'd1);
        @(posedge clk); #1;
        chk("abort_win_nodone", 32'(mon_done - d0), 32'd0);
        chk("abort_win_rstcnt", 32'(mon_rst - r0), 32'd2);

        // Asynchronous reset in the middle of a RUN.
        start_job(8'd1, 10'd7, 5'd2, 16'h0400, 16'h0300);
        knn_cfg_hs(10'd7, 5'd2, ok);
        map_hs = 1'b1;
        @(posedge clk); #1;
        map_hs  = 1'b0;
        crd_vld = 1'b1;
        #1;
        chk("pre_arst_map", 32'(map_addr_o), 32'h0301);
        chk("pre_arst_vld", 32'(glb_vld_o), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("arst_cfgrdy", 32'(cfg_rdy_o), 32'd1);
        chk("arst_vld", 32'(glb_vld_o), 32'd0);
        chk("arst_map", 32'(map_addr_o), 32'd0);
        chk("arst_nip", 32'(knn_nip_o), 32'd0);
        idle_inputs();
        #1 rst_n = 1'b1;
        @(posedge clk); #1;
        chk("arst_stall", stall_o, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
